// File: rtl/rotr_pkg.sv
// Shared types and helpers for the rotate scheduler.
//   state_e  : scheduler FSM states
//   SHIFT_W  : width of one rotate amount
//   id_w()   : width of a requester index for a given requester count
package rotr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SHIFT_W = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rotr_sched_if.sv
// Bundle of requester-side and rotator-side signals of rotr_sched.
//   req/req_a/req_shift : requests with flattened operands and amounts
//   gnt                 : one-hot grant pulse
//   rot_*               : rotator enable, operand, shift and returned result
//   res_*               : tagged result strobe
//   busy                : scheduler not idle
// master = environment (requesters + rotator), slave = scheduler.
interface rotr_sched_if
  import rotr_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_REQ    = 4
) ();
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*SHIFT_W-1:0]    req_shift;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rot_enable;
  logic [DATA_WIDTH-1:0]         rot_a;
  logic [DATA_WIDTH-1:0]         rot_shift;
  logic [DATA_WIDTH-1:0]         rot_result;
  logic                          res_valid;
  logic [ID_W-1:0]               res_id;
  logic [DATA_WIDTH-1:0]         res_data;
  logic                          busy;

  modport master (
    output req, req_a, req_shift, rot_result,
    input  gnt, rot_enable, rot_a, rot_shift, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req, req_a, req_shift, rot_result,
    output gnt, rot_enable, rot_a, rot_shift, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/rotr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
//   req    : request vector
//   ptr    : highest-priority index this round
//   win_oh : one-hot winner (zero when no request)
//   win_id : encoded winner index
module rr_arbiter
  import rotr_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_id
);

  int  idx;
  logic found;

  always_comb begin
    win_oh = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rotr_sched.sv
// Round-robin sequencer sharing one clocked rotate-right unit among NUM_REQ
// requesters. Captures the winner's operand/shift, pulses the rotator enable,
// waits ROT_LAT cycles and returns the result tagged with the requester id.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rotr_sched_if.slave (requests, grant, rotator, result, busy)
// Optional build macro ROTR_SCHED_ZERO_BYPASS_EN: a zero shift skips the
// rotator and completes in one cycle with res_data equal to the operand.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate and capture at the edge
// ISSUE | gnt pulse, rot_enable high, latency counter loaded
// WAIT  | counting down rotator latency; capture rot_result at count 0
// DONE  | res_valid pulse (bypass: gnt pulses here too)
module rotr_sched
  import rotr_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_REQ    = 4,
  parameter int ROT_LAT    = 1
) (
  input logic         clk,
  input logic         rst,
  rotr_sched_if.slave bus
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = (ROT_LAT > 1) ? $clog2(ROT_LAT) : 1;

  generate
    if (ROT_LAT < 1) begin : g_lat_chk
      $error("rotr_sched: ROT_LAT must be at least 1");
    end
  endgenerate

  state_e                state, state_nxt;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       win_id;
  logic [NUM_REQ-1:0]    win_oh;
  logic [DATA_WIDTH-1:0] win_a;
  logic [SHIFT_W-1:0]    win_shift;
  logic                  win_byp;
  logic [ID_W-1:0]       cap_id;
  logic [DATA_WIDTH-1:0] cap_a;
  logic [SHIFT_W-1:0]    cap_shift;
  logic                  cap_byp;
  logic [CNT_W-1:0]      cnt;
  logic [ID_W-1:0]       res_id;
  logic [DATA_WIDTH-1:0] res_data;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rot_enable;
  logic                  res_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .win_oh (win_oh),
    .win_id (win_id)
  );

  // AND-OR select of the winner's slices, driven by the one-hot pick
  always_comb begin
    win_a     = '0;
    win_shift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_a     = win_a | bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        win_shift = win_shift | bus.req_shift[i*SHIFT_W +: SHIFT_W];
      end
    end
  end

`ifdef ROTR_SCHED_ZERO_BYPASS_EN
  assign win_byp = (win_shift == '0);
`else
  assign win_byp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    rot_enable = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) state_nxt = win_byp ? DONE : ISSUE;
      end
      ISSUE: begin
        gnt        = NUM_REQ'(1) << cap_id;
        rot_enable = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        // a bypassed job never passed through ISSUE, so it is granted here
        if (cap_byp) gnt = NUM_REQ'(1) << cap_id;
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cap_id    <= '0;
      cap_a     <= '0;
      cap_shift <= '0;
      cap_byp   <= 1'b0;
      cnt       <= '0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            cap_id    <= win_id;
            cap_a     <= win_a;
            cap_shift <= win_shift;
            cap_byp   <= win_byp;
            if (int'(win_id) == NUM_REQ - 1) ptr <= '0;
            else                             ptr <= win_id + 1'b1;
            if (win_byp) begin
              res_id   <= win_id;
              res_data <= win_a;
            end
          end
        end
        ISSUE: cnt <= CNT_W'(ROT_LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            res_id   <= cap_id;
            res_data <= bus.rot_result;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = gnt;
  assign bus.rot_enable = rot_enable;
  assign bus.rot_a      = cap_a;
  assign bus.rot_shift  = {{(DATA_WIDTH-SHIFT_W){1'b0}}, cap_shift};
  assign bus.res_valid  = res_valid;
  assign bus.res_id     = res_id;
  assign bus.res_data   = res_data;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/rotr_sched.md
Name: rotr_sched

Overview:
- Sequencer and arbiter that shares one clocked 256-bit rotate-right datapath between NUM_REQ requesters.
- Arbitrates round-robin, captures the winner's operand and shift, and drives the rotator's enable and inputs.
- Waits the rotator's fixed latency, then returns the result tagged with the requester ID.
- Sits between the ALU issue logic and the rotate unit.

Parameters:
- DATA_WIDTH, 256, operand/result width.
- NUM_REQ, 4, number of requesters (>=2).
- ROT_LAT, 1, rotator latency in cycles from the enable cycle to a valid rot_result (>=1; 0 is an elaboration error).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  NUM_REQ  request per requester; level, held until its gnt bit pulses.
- req_a  input  NUM_REQ*DATA_WIDTH  flattened operands; slice i belongs to requester i.
- req_shift  input  NUM_REQ*8  flattened rotate amounts, 8 bits each.
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- rot_enable  output  1  enable to the rotator.
- rot_a  output  DATA_WIDTH  operand to the rotator.
- rot_shift  output  DATA_WIDTH  shift to the rotator; {zeros, 8-bit amount}.
- rot_result  input  DATA_WIDTH  rotator output.
- res_valid  output  1  result strobe, one cycle.
- res_id  output  $clog2(NUM_REQ)  requester index of the result.
- res_data  output  DATA_WIDTH  rotated result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high on clk.
  - State IDLE, rr pointer 0 (requester 0 highest priority).
  - gnt, rot_enable, res_valid, busy, res_id, res_data, rot_a and rot_shift all 0.
  - Reset mid-operation discards the in-flight job; no res_valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req != 0 in cycle T, arbitrate combinationally.
  - Winner is the first set bit at or after the pointer, wrapping.
  - At the edge: capture the winner's req_a slice, req_shift slice and index; set the pointer to winner+1 mod NUM_REQ; go to ISSUE.
- ISSUE (cycle T+1):
  - gnt[winner]=1 for exactly this cycle; rot_enable=1.
  - rot_a and rot_shift come from the captured registers.
  - Load latency counter with ROT_LAT-1; go to WAIT, or straight to DONE-capture when ROT_LAT=1.
- WAIT:
  - rot_enable=0; rot_a and rot_shift held stable.
  - Counter decrements once per cycle.
  - At the edge where the counter is 0, capture rot_result into res_data and go to DONE.
- Result capture: rot_result is sampled at the end of cycle T+1+ROT_LAT.
- DONE (cycle T+2+ROT_LAT): res_valid=1 with res_id and res_data for one cycle; go to IDLE.
- res_data and res_id hold their values until the next DONE.
- End-to-end latency: req seen to res_valid is ROT_LAT+2 cycles. Back-to-back throughput is one job per ROT_LAT+3 cycles.
- Requester obligations:
  - req must stay high until gnt; a requester may deassert during its gnt cycle.
  - req still high at the next IDLE is a new request.
  - req_a and req_shift must stay stable while req is high and not yet granted.
- Requests arriving while busy wait; nothing is queued beyond the req level.
- All requesters asserting simultaneously: service order is strictly round-robin (0,1,2,3,0,…).
- Pointer wrap: pointer NUM_REQ-1 wraps to 0.
- No backpressure on results.

Optional Feature:
- Macro: ROTR_SCHED_ZERO_BYPASS_EN.
- Defined:
  - If the captured shift is 0, IDLE goes directly to DONE.
  - gnt and res_valid are both asserted in cycle T+1, with res_data equal to the operand.
  - rot_enable is never asserted for that job; latency is 1 cycle.
  - The rr pointer updates as normal.
- Not defined: shift 0 follows the normal ISSUE/WAIT path with latency ROT_LAT+2.

Decomposition:
- Package rotr_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - localparam SHIFT_W=8;
  - helper function for the id width.
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer; output one-hot winner and encoded index; purely combinational.
- The FSM, counter and capture registers stay in rotr_sched.

Test Plan:
- Single request, ROT_LAT=1: req[2]=1, a=0x…0001, shift=4.
  - Expect gnt=4'b0100 at T+1, rot_enable at T+1, rot_shift=4.
  - Expect res_valid at T+3 with res_id=2 and res_data=bit 252 set (rotr by 4).
- Contention: req=4'b1111 held, with each requester dropping its req at its gnt.
  - Expect grant order 0,1,2,3.
  - Then req=4'b1001 from pointer 0 → 0 then 3.
- Latency: ROT_LAT=3, shift=255, a=0x1.
  - Expect rot_enable only at T+1, rot_a stable through WAIT.
  - Expect res_valid at T+5 with res_data=0x2.
- Reset mid-op: assert rst during WAIT.
  - Next cycle: state IDLE, busy=0, res_valid never pulses.
  - Following req[1] is granted first (pointer 0, only requester).
- Bypass:
  - With ROTR_SCHED_ZERO_BYPASS_EN: shift=0, a=0xDEAD → gnt and res_valid at T+1, res_data=0xDEAD, rot_enable stays 0.
  - Without the macro: the same stimulus gives res_valid at T+ROT_LAT+2.
